// File: rtl/ux607_tcm_init_pkg.sv
// Shared definitions for the TCM init/scrub initiator: FSM encoding, usr tag bit, size-code helper.
package ux607_tcm_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int USR_RD = 0;

    // Maps a data width to the uop size code log2(DW/8).
    function automatic logic [1:0] size_code(input int dw);
        logic [1:0] code;
        code = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if ((1 << i) == (dw / 8)) code = 2'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/ux607_tcm_init_if.sv
// uop cmd/rsp bus between the init initiator (master) and the SRAM controller (slave).
// A cmd transfers on a cycle where cmd_valid & cmd_ready are both high; once cmd_valid rises, it and all
// cmd payload stay stable until that transfer. Responses transfer whenever rsp_valid & rsp_ready.
interface ux607_tcm_init_if #(
    parameter int DW    = 64,
    parameter int MW    = 8,
    parameter int AW    = 32,
    parameter int USR_W = 3
);
    logic             uop_cmd_valid;
    logic             uop_cmd_ready;
    logic             uop_cmd_read;
    logic [AW-1:0]    uop_cmd_addr;
    logic [DW-1:0]    uop_cmd_wdata;
    logic [MW-1:0]    uop_cmd_wmask;
    logic [1:0]       uop_cmd_size;
    logic [USR_W-1:0] uop_cmd_usr;
    logic             uop_rsp_valid;
    logic             uop_rsp_ready;
    logic             uop_rsp_err;
    logic [DW-1:0]    uop_rsp_rdata;
    logic [USR_W-1:0] uop_rsp_usr;

    modport master (
        output uop_cmd_valid, uop_cmd_read, uop_cmd_addr, uop_cmd_wdata,
        output uop_cmd_wmask, uop_cmd_size, uop_cmd_usr, uop_rsp_ready,
        input  uop_cmd_ready, uop_rsp_valid, uop_rsp_err, uop_rsp_rdata, uop_rsp_usr
    );

    modport slave (
        input  uop_cmd_valid, uop_cmd_read, uop_cmd_addr, uop_cmd_wdata,
        input  uop_cmd_wmask, uop_cmd_size, uop_cmd_usr, uop_rsp_ready,
        output uop_cmd_ready, uop_rsp_valid, uop_rsp_err, uop_rsp_rdata, uop_rsp_usr
    );
endinterface

// File: rtl/ux607_tcm_init_outs_cnt.sv
// Outstanding-command counter: +1 per cmd handshake, -1 per response, with full and underflow flags.
module ux607_tcm_init_outs_cnt #(
    parameter int OUTS = 2,
    parameter int OW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [OW-1:0] cnt,
    output logic          full,
    output logic          underflow
);

    logic [OW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        underflow = dec && (cnt_q == '0);
        full      = (cnt_q >= OW'(OUTS));
        case ({inc, dec})
            2'b10:   cnt_d = cnt_q + OW'(1);
            2'b01:   if (cnt_q != '0) cnt_d = cnt_q - OW'(1);
            // A stray response at zero is dropped, so only the new command counts.
            2'b11:   if (cnt_q == '0) cnt_d = OW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ux607_tcm_init_mstr.sv
// TCM zero-init / scrub initiator: streams full-mask pattern writes over a word range, then drains.
// Optional read-back verify pass is enabled by defining UX607_TCM_INIT_VERIFY_EN.
module ux607_tcm_init_mstr
    import ux607_tcm_init_pkg::*;
#(
    parameter int DW    = 64,
    parameter int MW    = 8,
    parameter int AW    = 32,
    parameter int CNT_W = 16,
    parameter int USR_W = 3,
    parameter int OUTS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    cfg_base,
    input  logic [CNT_W-1:0] cfg_cnt,
    input  logic [DW-1:0]    cfg_pattern,
    output logic             busy,
    output logic             done,
    output logic             err,
`ifdef UX607_TCM_INIT_VERIFY_EN
    output logic [CNT_W-1:0] mism_cnt,
`endif
    output state_t           dbg_state,
    ux607_tcm_init_if.master uop
);

    localparam int BSH = $clog2(DW / 8);

    state_t           state_q, state_d;
    logic [AW-1:0]    base_q, base_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    pattern_q, pattern_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic             err_q, err_d;
`ifdef UX607_TCM_INIT_VERIFY_EN
    logic [CNT_W-1:0] mism_q, mism_d;
`endif

    logic [1:0]       outs_cnt;
    logic             outs_full, outs_unf;
    logic             cmd_valid, cmd_read, cmd_hs, rsp_bad;
    logic [USR_W-1:0] cmd_usr;
    logic             unused_sink;

    ux607_tcm_init_outs_cnt #(.OUTS(OUTS), .OW(2)) u_outs (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (cmd_hs),
        .dec       (uop.uop_rsp_valid),
        .cnt       (outs_cnt),
        .full      (outs_full),
        .underflow (outs_unf)
    );

    assign cmd_hs = cmd_valid & uop.uop_cmd_ready;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        index_d   = index_q;
        err_d     = err_q;
        cmd_read  = (state_q == ST_RD);
        // Valid depends only on registered state, so it cannot drop while waiting for ready.
        cmd_valid = ((state_q == ST_WR) || cmd_read) && (index_q < cnt_q) && !outs_full;
        cmd_usr   = '0;
        cmd_usr[USR_RD] = cmd_read;
        rsp_bad   = uop.uop_rsp_valid && (uop.uop_rsp_err || outs_unf);
`ifdef UX607_TCM_INIT_VERIFY_EN
        mism_d    = mism_q;
        if (uop.uop_rsp_valid && uop.uop_rsp_usr[USR_RD] && (uop.uop_rsp_rdata != pattern_q)) begin
            rsp_bad = 1'b1;
            if (mism_q != '1) mism_d = mism_q + CNT_W'(1);
        end
`endif
        if (rsp_bad) err_d = 1'b1;
        if (cmd_hs) index_d = index_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d    = {cfg_base[AW-1:BSH], {BSH{1'b0}}};
                    cnt_d     = cfg_cnt;
                    pattern_d = cfg_pattern;
                    index_d   = '0;
                    err_d     = 1'b0;
`ifdef UX607_TCM_INIT_VERIFY_EN
                    mism_d    = '0;
`endif
                    state_d   = (cfg_cnt == '0) ? ST_DRAIN : ST_WR;
                end
            end
            ST_WR: begin
                if (index_q == cnt_q) begin
`ifdef UX607_TCM_INIT_VERIFY_EN
                    state_d = ST_RD;
                    index_d = '0;
`else
                    state_d = ST_DRAIN;
`endif
                end
            end
`ifdef UX607_TCM_INIT_VERIFY_EN
            ST_RD: begin
                if (index_q == cnt_q) state_d = ST_DRAIN;
            end
`endif
            ST_DRAIN: begin
                if (outs_cnt == '0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            cnt_q     <= '0;
            pattern_q <= '0;
            index_q   <= '0;
            err_q     <= 1'b0;
`ifdef UX607_TCM_INIT_VERIFY_EN
            mism_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            index_q   <= index_d;
            err_q     <= err_d;
`ifdef UX607_TCM_INIT_VERIFY_EN
            mism_q    <= mism_d;
`endif
        end
    end

    assign busy      = (state_q == ST_WR) || (state_q == ST_RD) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign dbg_state = state_q;
`ifdef UX607_TCM_INIT_VERIFY_EN
    assign mism_cnt  = mism_q;
`endif

    assign uop.uop_cmd_valid = cmd_valid;
    assign uop.uop_cmd_read  = cmd_read;
    assign uop.uop_cmd_addr  = base_q + (AW'(index_q) << BSH);
    assign uop.uop_cmd_wdata = pattern_q;
    assign uop.uop_cmd_wmask = cmd_read ? {MW{1'b0}} : {MW{1'b1}};
    assign uop.uop_cmd_size  = size_code(DW);
    assign uop.uop_cmd_usr   = cmd_usr;
    assign uop.uop_rsp_ready = 1'b1;

    // Payload bits the engine deliberately ignores (aligned base, usr echo, write-pass rdata).
    assign unused_sink = ^{cfg_base[BSH-1:0], uop.uop_rsp_usr, uop.uop_rsp_rdata};

endmodule

// File: tb/tb_ux607_tcm_init_mstr.sv
// Directed bench for ux607_tcm_init_mstr with a responder model and an expected-command scoreboard.
module tb_ux607_tcm_init_mstr;
    import ux607_tcm_init_pkg::*;

    localparam int DW = 64, MW = 8, AW = 32, CNT_W = 16, USR_W = 3, OUTS = 2;
`ifdef UX607_TCM_INIT_VERIFY_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start;
    logic [AW-1:0]    cfg_base;
    logic [CNT_W-1:0] cfg_cnt;
    logic [DW-1:0]    cfg_pattern;
    logic             busy, done, err;
    state_t           dbg_state;
`ifdef UX607_TCM_INIT_VERIFY_EN
    logic [CNT_W-1:0] mism_cnt;
`endif

    ux607_tcm_init_if #(.DW(DW), .MW(MW), .AW(AW), .USR_W(USR_W)) uop_if ();

    ux607_tcm_init_mstr #(
        .DW(DW), .MW(MW), .AW(AW), .CNT_W(CNT_W), .USR_W(USR_W), .OUTS(OUTS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_base    (cfg_base),
        .cfg_cnt     (cfg_cnt),
        .cfg_pattern (cfg_pattern),
        .busy        (busy),
        .done        (done),
        .err         (err),
`ifdef UX607_TCM_INIT_VERIFY_EN
        .mism_cnt    (mism_cnt),
`endif
        .dbg_state   (dbg_state),
        .uop         (uop_if)
    );

    typedef struct {
        int          due;
        logic        rd;
        logic        err;
        logic [63:0] data;
    } rsp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [32:0] exp_q[$];
    rsp_t        rsp_q[$];
    int          hs_cyc[$];

    int          rsp_lat = 1;
    int          stall_from = -1;
    int          stall_to = -1;
    int          err_rsp_n = 0;
    int          bad_rd_n = 0;
    int          rd_cnt = 0;
    int          outs_model = 0;
    int          max_outs = 0;
    logic [63:0] tb_pattern = '0;
    logic        prev_hs = 1'b0;
    logic        prev_rsp = 1'b0;
    logic        pend = 1'b0;
    logic [AW-1:0] pend_addr;
    logic [63:0] pend_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Responder, ready driver and command monitor; everything happens on the falling edge.
    always @(negedge clk) begin
        logic hs;
        rsp_t r;
        logic [32:0] e;
        cyc++;
        if (!rst_n) begin
            rsp_q.delete();
            outs_model = 0;
            prev_hs = 1'b0;
            prev_rsp = 1'b0;
            pend = 1'b0;
            uop_if.uop_rsp_valid = 1'b0;
        end else begin
            outs_model = outs_model + int'(prev_hs) - int'(prev_rsp);
            uop_if.uop_cmd_ready = !(cyc >= stall_from && cyc <= stall_to);
            if (pend) begin
                chk("hold_valid", uop_if.uop_cmd_valid, 1);
                chk("hold_addr", uop_if.uop_cmd_addr, pend_addr);
                chk("hold_data", uop_if.uop_cmd_wdata, pend_data);
            end
            if (uop_if.uop_cmd_valid) chk("outs_limit", outs_model < OUTS, 1);
            if (outs_model > max_outs) max_outs = outs_model;
            chk("rsp_ready", uop_if.uop_rsp_ready, 1);
            hs = uop_if.uop_cmd_valid && uop_if.uop_cmd_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_rd_addr", {uop_if.uop_cmd_read, uop_if.uop_cmd_addr}, e);
                end
                chk("cmd_wdata", uop_if.uop_cmd_wdata, tb_pattern);
                chk("cmd_wmask", uop_if.uop_cmd_wmask, uop_if.uop_cmd_read ? 8'h00 : 8'hFF);
                chk("cmd_size", uop_if.uop_cmd_size, 2'b11);
                chk("cmd_usr", uop_if.uop_cmd_usr, {2'b00, uop_if.uop_cmd_read});
                hs_cyc.push_back(cyc);
                r.due = cyc + rsp_lat;
                r.rd = uop_if.uop_cmd_read;
                r.err = (hs_cyc.size() == err_rsp_n);
                r.data = tb_pattern;
                if (uop_if.uop_cmd_read) begin
                    rd_cnt++;
                    if (rd_cnt == bad_rd_n) r.data = '0;
                end
                rsp_q.push_back(r);
            end
            pend = uop_if.uop_cmd_valid && !uop_if.uop_cmd_ready;
            pend_addr = uop_if.uop_cmd_addr;
            pend_data = uop_if.uop_cmd_wdata;
            prev_rsp = 1'b0;
            uop_if.uop_rsp_valid = 1'b0;
            if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                uop_if.uop_rsp_valid = 1'b1;
                uop_if.uop_rsp_err = r.err;
                uop_if.uop_rsp_rdata = r.data;
                uop_if.uop_rsp_usr = {2'b00, r.rd};
                prev_rsp = 1'b1;
            end
            prev_hs = hs;
        end
    end

    int start_cyc;

    task automatic do_start(input logic [AW-1:0] base, input int cnt, input logic [63:0] pat,
                            input bit track);
        logic [32:0] ent;
        if (track) begin
            tb_pattern = pat;
            hs_cyc.delete();
            max_outs = 0;
            rd_cnt = 0;
            for (int p = 0; p < NPASS; p++) begin
                for (int i = 0; i < cnt; i++) begin
                    ent = {(p == 1), base + AW'(i * 8)};
                    exp_q.push_back(ent);
                end
            end
        end
        start_cyc = cyc;
        cfg_base = base;
        cfg_cnt = CNT_W'(cnt);
        cfg_pattern = pat;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        chk("done_seen", dcyc >= 0, 1);
        step(1);
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);
    endtask

    initial begin
        int d;
        start = 1'b0;
        cfg_base = '0;
        cfg_cnt = '0;
        cfg_pattern = '0;
        uop_if.uop_cmd_ready = 1'b1;
        uop_if.uop_rsp_valid = 1'b0;
        uop_if.uop_rsp_err = 1'b0;
        uop_if.uop_rsp_rdata = '0;
        uop_if.uop_rsp_usr = '0;

        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", uop_if.uop_cmd_valid, 0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst_n = 1'b1;
        step(1);

        // Back-to-back writes with 1-cycle responses.
        do_start(32'h100, 4, {8{8'hA5}}, 1);
        wait_done(d);
        chk("t1_hs_count", hs_cyc.size(), 4 * NPASS);
        chk("t1_back_to_back", hs_cyc[3] - hs_cyc[0], 3);
        chk("t1_done_latency", d - hs_cyc[hs_cyc.size() - 1], 3);
        chk("t1_err", err, 0);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Ready low for three cycles after the first issue.
        stall_from = cyc + 2;
        stall_to = cyc + 4;
        do_start(32'h1000, 4, 64'h0123_4567_89AB_CDEF, 1);
        wait_done(d);
        stall_from = -1;
        stall_to = -1;
        chk("t2_hs_count", hs_cyc.size(), 4 * NPASS);
        chk("t2_stall_gap", hs_cyc[3] - hs_cyc[0], 6);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Slow responses: the outstanding limit throttles issue.
        rsp_lat = 5;
        do_start(32'h2000, 4, 64'hDEAD_BEEF_0000_FFFF, 1);
        wait_done(d);
        chk("t3_hs_count", hs_cyc.size(), 4 * NPASS);
        chk("t3_max_outs", max_outs, OUTS);
        chk("t3_throttle_gap", hs_cyc[3] - hs_cyc[0], 7);
        chk("t3_done_latency", d - hs_cyc[hs_cyc.size() - 1], 7);
        chk("t3_sb_empty", exp_q.size(), 0);
        rsp_lat = 1;

        // Zero count, then a start while busy that must be ignored.
        do_start(32'h3000, 0, 64'h1111_2222_3333_4444, 1);
        wait_done(d);
        chk("t4_zero_done_lat", d - start_cyc, 2);
        chk("t4_zero_no_cmd", hs_cyc.size(), 0);
        do_start(32'h200, 3, 64'h5555_6666_7777_8888, 1);
        do_start(32'h800, 5, 64'h9999_AAAA_BBBB_CCCC, 0);
        wait_done(d);
        chk("t4_ignored_start", hs_cyc.size(), 3 * NPASS);
        chk("t4_sb_empty", exp_q.size(), 0);

        // Error on the third response, cleared by the next start.
        err_rsp_n = 3;
        do_start(32'h400, 4, 64'hA5A5_5A5A_A5A5_5A5A, 1);
        wait_done(d);
        chk("t5_err_set", err, 1);
        err_rsp_n = 0;
        do_start(32'h500, 2, 64'hA5A5_5A5A_A5A5_5A5A, 1);
        chk("t5_err_cleared", err, 0);
        wait_done(d);
        chk("t5_err_stays_clear", err, 0);
        chk("t5_sb_empty", exp_q.size(), 0);

`ifdef UX607_TCM_INIT_VERIFY_EN
        // Read-back with one corrupted word.
        bad_rd_n = 2;
        do_start(32'h600, 2, 64'hCAFE_F00D_CAFE_F00D, 1);
        wait_done(d);
        chk("t6_hs_count", hs_cyc.size(), 4);
        chk("t6_mism_cnt", mism_cnt, 1);
        chk("t6_err", err, 1);
        chk("t6_sb_empty", exp_q.size(), 0);
        bad_rd_n = 0;
`endif

        // Reset in the middle of a stalled write sweep with err already set.
        err_rsp_n = 1;
        stall_from = cyc + 2;
        stall_to = cyc + 1000;
        do_start(32'h700, 4, 64'h0F0F_0F0F_0F0F_0F0F, 1);
        step(3);
        chk("t7_err_pre", err, 1);
        chk("t7_busy_pre", busy, 1);
        rst_n = 1'b0;
        step(1);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_done", done, 0);
        chk("t7_rst_err", err, 0);
        chk("t7_rst_valid", uop_if.uop_cmd_valid, 0);
        chk("t7_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        exp_q.delete();
        stall_from = -1;
        stall_to = -1;
        err_rsp_n = 0;
        rst_n = 1'b1;
        step(1);

        // Recovery sweep after the abort.
        do_start(32'h808, 1, 64'h1234_5678_9ABC_DEF0, 1);
        wait_done(d);
        chk("t8_hs_count", hs_cyc.size(), NPASS);
        chk("t8_err", err, 0);
        chk("t8_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
